// File: rtl/kws_feature_loader_pkg.sv
// Shared register map, CTRL/STATUS bit positions and loader FSM states.
package kws_feature_loader_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_FCNT   = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_FULL  = 8;
  localparam int unsigned STAT_EMPTY = 9;
  localparam int unsigned STAT_FDONE = 10;
  localparam int unsigned STAT_OVF   = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/kws_feature_loader_if.sv
// Wishbone slave bus plus feature stream towards cmvn, with the block's irq line.
interface kws_feature_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        feat_valid_o;
  logic        feat_ready_i;
  logic [31:0] feat_data_o;
  logic [4:0]  feat_addr_o;
  logic        feat_last_o;
  logic        irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, feat_ready_i,
    output wbs_ack_o, wbs_dat_o, feat_valid_o, feat_data_o, feat_addr_o, feat_last_o, irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, feat_ready_i,
    input  wbs_ack_o, wbs_dat_o, feat_valid_o, feat_data_o, feat_addr_o, feat_last_o, irq_o
  );
endinterface

// File: rtl/kws_sync_fifo.sv
// Synchronous FIFO; pushes when full are dropped, pops when empty are ignored.
module kws_sync_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full & ~i_clr;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/kws_feature_loader.sv
// Wishbone-fed feature buffer streaming (data, addr) words to cmvn, with frame counting and irq.
module kws_feature_loader
  import kws_feature_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned FRAME_LEN = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  kws_feature_loader_if.slave  bus
);
  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [4:0]  LAST_ADDR = 5'(FRAME_LEN - 1);

  state_t        r_state, w_state_nxt;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_enable, r_irq_en, r_fdone, r_ovf, r_irq;
  logic [15:0]   r_fcnt;
  logic [4:0]    r_addr;
  logic          r_valid;
  logic [31:0]   r_data;

  logic          w_hit, w_acc, w_wr, w_ctrl_wr, w_stat_wr, w_push, w_flush;
  logic          w_in_flush, w_valid, w_xfer, w_load, w_frame_end;
  logic [1:0]    w_reg;
  logic [31:0]   w_fifo_data, w_status, w_rdata;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count;
  logic          w_unused;

  assign w_hit     = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_acc     = w_hit & ~r_ack;
  assign w_reg     = bus.wbs_adr_i[3:2];
  assign w_wr      = w_acc & bus.wbs_we_i;
  assign w_ctrl_wr = w_wr & (w_reg == REG_CTRL) & bus.wbs_sel_i[0];
  assign w_stat_wr = w_wr & (w_reg == REG_STATUS) & bus.wbs_sel_i[1];
  assign w_push    = w_wr & (w_reg == REG_DATA) & (bus.wbs_sel_i == 4'hF);
  assign w_flush   = w_ctrl_wr & bus.wbs_dat_i[CTRL_FLUSH];
  assign w_unused  = ^bus.wbs_adr_i[1:0];

  // The held word is masked during the flush cycle so no transfer can race the clear.
  assign w_in_flush  = (r_state == S_FLUSH);
  assign w_valid     = r_valid & ~w_in_flush;
  assign w_xfer      = w_valid & bus.feat_ready_i;
  assign w_load      = (r_state == S_RUN) & ~w_empty & (~r_valid | bus.feat_ready_i);
  assign w_frame_end = w_xfer & (r_addr == LAST_ADDR);

  kws_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_clr   (w_in_flush),
    .i_push  (w_push),
    .i_data  (bus.wbs_dat_i),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status             = '0;
    w_status[6:0]        = 7'(w_count);
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FDONE] = r_fdone;
    w_status[STAT_OVF]   = r_ovf;
    unique case (w_reg)
      REG_CTRL:   w_rdata = {29'b0, r_irq_en, 1'b0, r_enable};
      REG_STATUS: w_rdata = w_status;
      REG_FCNT:   w_rdata = {16'b0, r_fcnt};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~bus.wbs_we_i) ? w_rdata : '0;
    end
  end

  // Later assignments win: overflow set beats W1C, frame completion beats W1C of frame_done.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_fdone  <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= bus.wbs_dat_i[CTRL_EN];
        r_irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (w_stat_wr && bus.wbs_dat_i[STAT_OVF])   r_ovf <= 1'b0;
      if (w_push && w_full)                       r_ovf <= 1'b1;
      if (w_in_flush)                             r_ovf <= 1'b0;
      if (w_stat_wr && bus.wbs_dat_i[STAT_FDONE]) r_fdone <= 1'b0;
      if (w_frame_end)                            r_fdone <= 1'b1;
      if (w_frame_end)                            r_fcnt <= r_fcnt + 1'b1;
      r_irq <= w_frame_end & r_irq_en;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else if (w_in_flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      if (w_xfer) r_addr <= w_frame_end ? 5'd0 : r_addr + 5'd1;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_fifo_data;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (r_enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!r_enable) w_state_nxt = S_IDLE;
      S_FLUSH: w_state_nxt = r_enable ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) w_state_nxt = S_FLUSH;
  end

  assign bus.wbs_ack_o    = r_ack;
  assign bus.wbs_dat_o    = r_dat;
  assign bus.feat_valid_o = w_valid;
  assign bus.feat_data_o  = r_data;
  assign bus.feat_addr_o  = r_addr;
  assign bus.feat_last_o  = w_valid & (r_addr == LAST_ADDR);
  assign bus.irq_o        = r_irq;
endmodule

// File: tb/tb_kws_feature_loader.sv
// Directed bench for kws_feature_loader: CSRs, framing, overflow, backpressure, flush, decode misses, reset.
module tb_kws_feature_loader;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned FRAME_LEN = 32;
  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0;
  localparam logic [31:0] A_STAT    = BASE + 32'h4;
  localparam logic [31:0] A_DATA    = BASE + 32'h8;
  localparam logic [31:0] A_FCNT    = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kws_feature_loader_if bus_if();

  kws_feature_loader #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  int n_irq    = 0;
  int xfer_limit = 1 << 30;
  int rdy_mode = 0;
  int epoch = 0;
  bit hold_skip = 1'b0;
  logic [31:0] exp_mem [0:511];
  int wr_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic acked, output logic [31:0] rdat);
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_dat_i = dat;
    bus_if.wbs_sel_i = sel;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = bus_if.wbs_dat_o;
        break;
      end
    end
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic a;
    logic [31:0] d;
    wb_access(1'b1, adr, dat, sel, a, d);
    chk("wr_ack", a, 1);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic a;
    logic [31:0] d;
    wb_access(1'b0, adr, 32'h0, 4'hF, a, d);
    chk({tag, "_ack"}, a, 1);
    chk(tag, d, exp);
  endtask

  task automatic push(input logic [31:0] w, input bit kept);
    if (kept) begin
      exp_mem[wr_idx] = w;
      wr_idx++;
    end
    wb_wr(A_DATA, w, 4'hF);
  endtask

  task automatic wait_xfer(input string tag, input int target);
    for (int i = 0; i < 3000 && n_xfer < target; i++) @(negedge clk);
    chk(tag, n_xfer, target);
  endtask

  // ready driver: 0 = stalled, 1 = ready until xfer_limit transfers, 2 = fixed on/off pattern
  initial begin
    logic [15:0] pat;
    int k;
    pat = 16'b1011_0010_1110_0101;
    k = 0;
    bus_if.feat_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus_if.feat_ready_i = 1'b0;
        1:       bus_if.feat_ready_i = (n_xfer < xfer_limit);
        default: begin
          bus_if.feat_ready_i = pat[k];
          k = (k + 1) % 16;
        end
      endcase
    end
  end

  // stream monitor: order, addr/last, hold stability, irq pulses
  initial begin
    int rd_idx;
    int seen_epoch;
    logic [4:0] exp_addr;
    logic prev_hold;
    logic [36:0] prev_word;
    rd_idx = 0;
    seen_epoch = 0;
    exp_addr = '0;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        rd_idx = wr_idx;
        exp_addr = '0;
        seen_epoch = epoch;
      end
      if (hold_skip || rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          chk("hold_stable", {bus_if.feat_valid_o, bus_if.feat_addr_o, bus_if.feat_data_o}, {1'b1, prev_word});
        if (bus_if.feat_valid_o && bus_if.feat_ready_i) begin
          chk("word_expected", rd_idx < wr_idx, 1);
          if (rd_idx < wr_idx) begin
            chk("xfer_data", bus_if.feat_data_o, exp_mem[rd_idx]);
            rd_idx++;
          end
          chk("xfer_addr_last", {bus_if.feat_addr_o, bus_if.feat_last_o},
              {exp_addr, exp_addr == 5'(FRAME_LEN - 1)});
          exp_addr = (exp_addr == 5'(FRAME_LEN - 1)) ? 5'd0 : exp_addr + 5'd1;
          n_xfer++;
        end
        prev_hold = bus_if.feat_valid_o & ~bus_if.feat_ready_i;
        prev_word = {bus_if.feat_addr_o, bus_if.feat_data_o};
      end
      if (bus_if.irq_o) n_irq++;
    end
  end

  initial begin
    logic a;
    logic [31:0] d;
    rst = 1'b1;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_sel_i = 4'h0;
    bus_if.wbs_adr_i = '0;
    bus_if.wbs_dat_i = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bus_if.wbs_ack_o, bus_if.feat_valid_o, bus_if.feat_last_o, bus_if.irq_o, bus_if.feat_addr_o}, 0);
    chk("rst_wbdat", bus_if.wbs_dat_o, 0);
    chk("rst_fdata", bus_if.feat_data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd("rst_status", A_STAT, 32'h200);
    wb_rd("rst_ctrl", A_CTRL, 32'h0);
    wb_rd("rst_fcnt", A_FCNT, 32'h0);

    // 2: one full frame with ready held high
    rdy_mode = 1;
    wb_wr(A_CTRL, 32'h5, 4'hF);
    wb_rd("ctrl_rb", A_CTRL, 32'h5);
    for (int i = 0; i < 32; i++) push(32'(i), 1'b1);
    wait_xfer("f1_xfers", 32);
    repeat (3) @(negedge clk);
    chk("f1_irq", n_irq, 1);
    wb_rd("f1_fcnt", A_FCNT, 32'd1);
    wb_rd("f1_status", A_STAT, 32'h600);

    // 3: overflow while disabled and stalled
    rdy_mode = 0;
    wb_wr(A_CTRL, 32'h4, 4'hF);
    for (int i = 0; i < 33; i++) push(32'h100 + 32'(i), i < 32);
    wb_rd("ovf_status", A_STAT, 32'hD20);
    chk("idle_no_valid", bus_if.feat_valid_o, 0);
    rdy_mode = 1;
    wb_wr(A_CTRL, 32'h5, 4'hF);
    wait_xfer("f2_xfers", 64);
    repeat (3) @(negedge clk);
    chk("f2_irq", n_irq, 2);
    wb_rd("f2_fcnt", A_FCNT, 32'd2);
    wb_wr(A_STAT, 32'hC00, 4'h2);
    wb_rd("w1c_status", A_STAT, 32'h200);

    // 4: three frames under patterned backpressure
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) push(32'h1000 + 32'(f * 32 + i), 1'b1);
      wait_xfer("bp_xfers", 96 + 32 * f);
    end
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("bp_irq", n_irq, 5);
    wb_rd("bp_fcnt", A_FCNT, 32'd5);

    // 5: flush with the word at addr 10 held
    xfer_limit = 170;
    for (int i = 0; i < 20; i++) push(32'h2000 + 32'(i), 1'b1);
    wait_xfer("pre_flush_xfers", 170);
    @(negedge clk);
    chk("held_at_10", {bus_if.feat_valid_o, bus_if.feat_addr_o}, {1'b1, 5'd10});
    hold_skip = 1'b1;
    wb_wr(A_CTRL, 32'h7, 4'hF);
    chk("flush_valid", bus_if.feat_valid_o, 0);
    epoch++;
    repeat (2) @(negedge clk);
    hold_skip = 1'b0;
    wb_rd("flush_status", A_STAT, 32'h600);
    wb_rd("flush_fcnt", A_FCNT, 32'd5);
    xfer_limit = 1 << 30;
    push(32'hABCD, 1'b1);
    wait_xfer("post_flush_xfer", 171);

    // 6: decode misses and ignored writes
    wb_wr(A_CTRL, 32'h4, 4'hF);
    push(32'h3000, 1'b1);
    push(32'h3001, 1'b1);
    wb_rd("fill2_status", A_STAT, 32'h402);
    wb_access(1'b1, 32'h4000_0008, 32'h5555, 4'hF, a, d);
    chk("miss_no_ack", a, 0);
    wb_wr(A_DATA, 32'h6666, 4'h7);
    wb_rd("bad_push_status", A_STAT, 32'h402);
    wb_rd("data_reads_0", A_DATA, 32'h0);
    wb_wr(A_FCNT, 32'h1234, 4'hF);
    wb_rd("fcnt_ro", A_FCNT, 32'd5);
    wb_wr(A_STAT, 32'h400, 4'h2);
    wb_rd("w1c_fdone", A_STAT, 32'h002);

    // asynchronous reset while a word is held
    rdy_mode = 0;
    wb_wr(A_CTRL, 32'h5, 4'hF);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", bus_if.feat_valid_o, 1);
    hold_skip = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {bus_if.feat_valid_o, bus_if.feat_addr_o, bus_if.feat_data_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_skip = 1'b0;
    wb_rd("rst2_status", A_STAT, 32'h200);
    wb_rd("rst2_ctrl", A_CTRL, 32'h0);
    wb_rd("rst2_fcnt", A_FCNT, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
